// File: rtl/id_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// The stage itself plugs in through the slave modport.
interface id_pipe_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_aluop;
    logic [2:0]      out_class;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [XLEN-1:0] out_store_data;
    logic [4:0]      out_rd;
    logic            out_wr_en;
    logic            out_mem_valid;
    logic            out_mem_rw;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    modport master (
        output in_valid,
        output in_inst,
        output in_pc,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_aluop,
        input  out_class,
        input  out_op1,
        input  out_op2,
        input  out_store_data,
        input  out_rd,
        input  out_wr_en,
        input  out_mem_valid,
        input  out_mem_rw,
        input  out_pc,
        input  out_illegal
    );

    modport slave (
        input  in_valid,
        input  in_inst,
        input  in_pc,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_aluop,
        output out_class,
        output out_op1,
        output out_op2,
        output out_store_data,
        output out_rd,
        output out_wr_en,
        output out_mem_valid,
        output out_mem_rw,
        output out_pc,
        output out_illegal
    );
endinterface

// File: rtl/id_pipe.sv
// Registered decode stage: decode, EX/MEM forwarding, load-use stall,
// ID/EX output register with valid/ready handshake and bubble counter.
module id_pipe #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    id_pipe_if.slave         bus,
    output logic [4:0]       rf_rs1_addr,
    output logic [4:0]       rf_rs2_addr,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    input  logic             ex_wr_en,
    input  logic [4:0]       ex_wr_addr,
    input  logic [XLEN-1:0]  ex_wr_data,
    input  logic             mem_wr_en,
    input  logic [4:0]       mem_wr_addr,
    input  logic [XLEN-1:0]  mem_wr_data,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] C_OP    = 3'd0;
    localparam logic [2:0] C_OPIMM = 3'd1;
    localparam logic [2:0] C_LUI   = 3'd2;
    localparam logic [2:0] C_AUIPC = 3'd3;
    localparam logic [2:0] C_LOAD  = 3'd4;
    localparam logic [2:0] C_STORE = 3'd5;
    localparam logic [2:0] C_ILL   = 3'd7;

    typedef struct packed {
        logic [2:0]      cls;
        logic [3:0]      aluop;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] sd;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            wr_en;
        logic            mem_valid;
        logic            mem_rw;
        logic            illegal;
    } id_ex_t;

    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            is_op;
    logic            is_opi;
    logic            is_lui;
    logic            is_auipc;
    logic            is_load;
    logic            is_store;
    logic            use_rs1;
    logic            use_rs2;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            hazard;
    logic            adv;
    logic            take;

    id_ex_t d;
    id_ex_t q;
    logic   q_valid;

    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    assign is_op    = opcode == OPC_OP;
    assign is_opi   = opcode == OPC_OPIMM;
    assign is_lui   = opcode == OPC_LUI;
    assign is_auipc = opcode == OPC_AUIPC;
    assign is_load  = opcode == OPC_LOAD;
    assign is_store = opcode == OPC_STORE;

    assign use_rs1 = is_op | is_opi | is_load | is_store;
    assign use_rs2 = is_op | is_store;

    // U-type is sign-extended from bit 31 on RV64
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));

    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      a,
        input logic [XLEN-1:0] rf,
        input logic            e_en,
        input logic [4:0]      e_addr,
        input logic [XLEN-1:0] e_data,
        input logic            m_en,
        input logic [4:0]      m_addr,
        input logic [XLEN-1:0] m_data
    );
        logic [XLEN-1:0] v;
        if (a == 5'd0)
            v = '0;
        else if (e_en && e_addr == a)
            v = e_data;
        else if (m_en && m_addr == a)
            v = m_data;
        else
            v = rf;
        return v;
    endfunction

    assign rs1_val = fwd(rs1, rf_rs1_data,
                         ex_wr_en, ex_wr_addr, ex_wr_data,
                         mem_wr_en, mem_wr_addr, mem_wr_data);
    assign rs2_val = fwd(rs2, rf_rs2_data,
                         ex_wr_en, ex_wr_addr, ex_wr_data,
                         mem_wr_en, mem_wr_addr, mem_wr_data);

    always_comb begin
        d     = '0;
        d.pc  = bus.in_pc;
        unique case (1'b1)
            is_op: begin
                d.cls   = C_OP;
                d.aluop = {inst[30], funct3};
                d.op1   = rs1_val;
                d.op2   = rs2_val;
                d.rd    = rd;
                d.wr_en = rd != 5'd0;
            end
            is_opi: begin
                d.cls   = C_OPIMM;
                d.aluop = {inst[30] & (funct3 == 3'b101), funct3};
                d.op1   = rs1_val;
                d.op2   = imm_i;
                d.rd    = rd;
                d.wr_en = rd != 5'd0;
            end
            is_lui: begin
                d.cls   = C_LUI;
                d.op2   = imm_u;
                d.rd    = rd;
                d.wr_en = rd != 5'd0;
            end
            is_auipc: begin
                d.cls   = C_AUIPC;
                d.op1   = bus.in_pc;
                d.op2   = imm_u;
                d.rd    = rd;
                d.wr_en = rd != 5'd0;
            end
            is_load: begin
                d.cls       = C_LOAD;
                d.aluop     = {1'b0, funct3};
                d.op1       = rs1_val;
                d.op2       = imm_i;
                d.rd        = rd;
                d.wr_en     = rd != 5'd0;
                d.mem_valid = 1'b1;
            end
            is_store: begin
                d.cls       = C_STORE;
                d.aluop     = {1'b0, funct3};
                d.op1       = rs1_val;
                d.op2       = imm_s;
                d.sd        = rs2_val;
                d.mem_valid = 1'b1;
                d.mem_rw    = 1'b1;
            end
            default: begin
                d.cls     = C_ILL;
                d.illegal = 1'b1;
            end
        endcase
    end

    assign hazard = q_valid && q.cls == C_LOAD && q.rd != 5'd0
                 && bus.in_valid
                 && ((use_rs1 && rs1 == q.rd)
                  || (use_rs2 && rs2 == q.rd));

    assign adv          = !q_valid || bus.out_ready;
    assign take         = bus.in_valid && !hazard;
    assign bus.in_ready = flush || (adv && !hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            q_valid    <= 1'b0;
            bubble_cnt <= '0;
        end else if (flush) begin
            q_valid <= 1'b0;
        end else if (adv) begin
            q_valid <= take;
            if (take)
                q <= d;
            if (hazard && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid      = q_valid;
    assign bus.out_class      = q.cls;
    assign bus.out_aluop      = q.aluop;
    assign bus.out_op1        = q.op1;
    assign bus.out_op2        = q.op2;
    assign bus.out_store_data = q.sd;
    assign bus.out_rd         = q.rd;
    assign bus.out_wr_en      = q.wr_en;
    assign bus.out_mem_valid  = q.mem_valid;
    assign bus.out_mem_rw     = q.mem_rw;
    assign bus.out_pc         = q.pc;
    assign bus.out_illegal    = q.illegal;

endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: directed instructions, expected ID/EX bundles queued
// at acceptance and compared by a monitor when EX takes them.
module tb_id_pipe;

    typedef struct packed {
        logic [2:0]  cls;
        logic [3:0]  aluop;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] sd;
        logic [4:0]  rd;
        logic        wr;
        logic        mv;
        logic        rw;
        logic [63:0] pc;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [63:0] rf1;
    logic [63:0] rf2;
    logic        ex_en;
    logic [4:0]  ex_addr;
    logic [63:0] ex_data;
    logic        mem_en;
    logic [4:0]  mem_addr;
    logic [63:0] mem_data;
    logic [31:0] bubble_cnt;

    int   checks;
    int   failures;
    exp_t exp_q[$];

    id_pipe_if #(.XLEN(64)) bus ();

    id_pipe #(.XLEN(64), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .rf_rs1_addr (rf_rs1_addr),
        .rf_rs2_addr (rf_rs2_addr),
        .rf_rs1_data (rf1),
        .rf_rs2_data (rf2),
        .ex_wr_en    (ex_en),
        .ex_wr_addr  (ex_addr),
        .ex_wr_data  (ex_data),
        .mem_wr_en   (mem_en),
        .mem_wr_addr (mem_addr),
        .mem_wr_data (mem_data),
        .bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [299:0] act,
                       input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(
        input logic [2:0] cls, input logic [3:0] aluop,
        input logic [63:0] op1, input logic [63:0] op2,
        input logic [63:0] sd, input logic [4:0] rd,
        input logic wr, input logic mv, input logic rw,
        input logic [63:0] pc, input logic ill);
        exp_t e;
        e.cls = cls; e.aluop = aluop; e.op1 = op1; e.op2 = op2;
        e.sd = sd; e.rd = rd; e.wr = wr; e.mv = mv; e.rw = rw;
        e.pc = pc; e.ill = ill;
        return e;
    endfunction

    // Monitor: compare whenever EX takes an instruction
    always @(negedge clk) begin : monitor
        exp_t a;
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            a.cls = bus.out_class; a.aluop = bus.out_aluop;
            a.op1 = bus.out_op1; a.op2 = bus.out_op2;
            a.sd = bus.out_store_data; a.rd = bus.out_rd;
            a.wr = bus.out_wr_en; a.mv = bus.out_mem_valid;
            a.rw = bus.out_mem_rw; a.pc = bus.out_pc;
            a.ill = bus.out_illegal;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out act=%h exp=none", a);
            end else begin
                e = exp_q.pop_front();
                chk("out_bundle", 300'(a), 300'(e));
            end
        end
    end

    task automatic issue(input logic [31:0] i, input logic [63:0] pc,
                         input exp_t e);
        bus.in_valid = 1'b1;
        bus.in_inst  = i;
        bus.in_pc    = pc;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        failures++;
        $display("FAIL issue_timeout act=no_accept exp=accept");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
        bus.out_ready = 1'b1;
        rf1 = '0; rf2 = '0;
        ex_en = 0; ex_addr = '0; ex_data = '0;
        mem_en = 0; mem_addr = '0; mem_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 300'(bus.out_valid), 300'(1'b0));
        chk("rst_cnt", 300'(bubble_cnt), 300'(32'd0));
        chk("rst_op2", 300'(bus.out_op2), 300'(64'd0));
        chk("rst_class", 300'(bus.out_class), 300'(3'd0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 300'(bus.in_ready), 300'(1'b1));
        @(posedge clk);
        #1;

        // addi x1,x0,5
        issue(32'h00500093, 64'h100,
              mk(3'd1, 4'h0, 64'd0, 64'd5, 64'd0, 5'd1,
                 1, 0, 0, 64'h100, 0));
        chk("latency_valid", 300'(bus.out_valid), 300'(1'b1));

        // add x3,x1,x2 with EX and MEM both matching x1: EX wins
        rf1 = 64'd11; rf2 = 64'd4;
        ex_en = 1; ex_addr = 5'd1; ex_data = 64'd7;
        mem_en = 1; mem_addr = 5'd1; mem_data = 64'd9;
        issue(32'h002081B3, 64'h104,
              mk(3'd0, 4'h0, 64'd7, 64'd4, 64'd0, 5'd3,
                 1, 0, 0, 64'h104, 0));
        // add x3,x0,x2 with EX/MEM writing x0: x0 reads zero
        ex_addr = 5'd0; mem_addr = 5'd0;
        issue(32'h002001B3, 64'h108,
              mk(3'd0, 4'h0, 64'd0, 64'd4, 64'd0, 5'd3,
                 1, 0, 0, 64'h108, 0));
        // MEM-only forward onto rs2
        ex_addr = 5'd5; mem_addr = 5'd2;
        issue(32'h002081B3, 64'h10C,
              mk(3'd0, 4'h0, 64'd11, 64'd9, 64'd0, 5'd3,
                 1, 0, 0, 64'h10C, 0));
        ex_en = 0; mem_en = 0;
        // sub x7,x1,x2 and srai x8,x1,3
        issue(32'h402083B3, 64'h110,
              mk(3'd0, 4'h8, 64'd11, 64'd4, 64'd0, 5'd7,
                 1, 0, 0, 64'h110, 0));
        issue(32'h4030D413, 64'h114,
              mk(3'd1, 4'hD, 64'd11, 64'h403, 64'd0, 5'd8,
                 1, 0, 0, 64'h114, 0));

        // lw x5,8(x2) then add x6,x5,x1
        rf1 = 64'h1000;
        issue(32'h00812283, 64'h118,
              mk(3'd4, 4'h2, 64'h1000, 64'd8, 64'd0, 5'd5,
                 1, 1, 0, 64'h118, 0));
        rf2 = 64'd22;
        bus.in_valid = 1'b1; bus.in_inst = 32'h00128333;
        bus.in_pc = 64'h11C;
        @(negedge clk);
        chk("hazard_in_ready", 300'(bus.in_ready), 300'(1'b0));
        @(posedge clk);
        #1;
        mem_en = 1; mem_addr = 5'd5; mem_data = 64'hABC;
        @(negedge clk);
        chk("bubble_valid", 300'(bus.out_valid), 300'(1'b0));
        chk("bubble_cnt1", 300'(bubble_cnt), 300'(32'd1));
        chk("post_bubble_ready", 300'(bus.in_ready), 300'(1'b1));
        exp_q.push_back(mk(3'd0, 4'h0, 64'hABC, 64'd22, 64'd0, 5'd6,
                           1, 0, 0, 64'h11C, 0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; mem_en = 0;
        repeat (2) @(posedge clk);
        #1;

        // back-pressure: addi x9,x0,-1 held, sw x2,12(x1) pending
        rf1 = 64'h300; rf2 = 64'h55;
        bus.out_ready = 1'b0;
        issue(32'hFFF00493, 64'h120,
              mk(3'd1, 4'h0, 64'd0, '1, 64'd0, 5'd9,
                 1, 0, 0, 64'h120, 0));
        bus.in_valid = 1'b1; bus.in_inst = 32'h0020A623;
        bus.in_pc = 64'h124;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", 300'(bus.out_valid), 300'(1'b1));
            chk("bp_in_ready", 300'(bus.in_ready), 300'(1'b0));
            chk("bp_hold", 300'({bus.out_op2, bus.out_rd}),
                300'({64'hFFFF_FFFF_FFFF_FFFF, 5'd9}));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 300'(bus.in_ready), 300'(1'b1));
        exp_q.push_back(mk(3'd5, 4'h2, 64'h300, 64'd12, 64'h55, 5'd0,
                           0, 1, 1, 64'h124, 0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;

        // flush while a load is held and a dependent add waits
        issue(32'h00812283, 64'h128,
              mk(3'd4, 4'h2, 64'h300, 64'd8, 64'd0, 5'd5,
                 1, 1, 0, 64'h128, 0));
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_inst = 32'h00128333;
        bus.in_pc = 64'h12C;
        @(negedge clk);
        chk("fl_pre_ready", 300'(bus.in_ready), 300'(1'b0));
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("fl_in_ready", 300'(bus.in_ready), 300'(1'b1));
        @(posedge clk);
        #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("fl_valid", 300'(bus.out_valid), 300'(1'b0));
        chk("fl_cnt", 300'(bubble_cnt), 300'(32'd1));
        chk("fl_ready_after", 300'(bus.in_ready), 300'(1'b1));
        @(posedge clk);
        #1 bus.out_ready = 1'b1;

        // lui x4,0x80000 ; auipc x10,0x1 ; illegal opcode 0x7F
        issue(32'h80000237, 64'h200,
              mk(3'd2, 4'h0, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'd0,
                 5'd4, 1, 0, 0, 64'h200, 0));
        issue(32'h00001517, 64'h204,
              mk(3'd3, 4'h0, 64'h204, 64'h1000, 64'd0, 5'd10,
                 1, 0, 0, 64'h204, 0));
        issue(32'h0000007F, 64'h208,
              mk(3'd7, 4'h0, 64'd0, 64'd0, 64'd0, 5'd0,
                 0, 0, 0, 64'h208, 1));

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 300'(exp_q.size()), 300'(0));
        chk("final_cnt", 300'(bubble_cnt), 300'(32'd1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_pipe.md
# id_pipe

Parametrised, registered decode stage for the RV core. It sits between fetch and execute and decodes OP, OP-IMM, LUI, AUIPC, LOAD and STORE. It forwards operands from EX and MEM, and detects load-use hazards, inserting one bubble for each. It drives a registered ID/EX output with a valid/ready handshake, accepts a flush, and counts stall bubbles.

## Interface
- XLEN, 64, datapath width; 32 or 64.
- CNT_W, 32, width of the bubble counter.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard the output register and the current input
- in_valid  in  1  fetch offers in_inst/in_pc
- in_ready  out  1  decode accepts this cycle
- in_inst  in  32  instruction
- in_pc  in  XLEN  instruction PC
- rf_rs1_addr, rf_rs2_addr  out  5  combinational inst[19:15] and inst[24:20]
- rf_rs1_data, rf_rs2_data  in  XLEN  register file read data, same cycle
- ex_wr_en, ex_wr_addr, ex_wr_data  in  1/5/XLEN  EX result of the instruction now in this block's output register
- mem_wr_en, mem_wr_addr, mem_wr_data  in  1/5/XLEN  MEM-stage result
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  EX accepts
- out_aluop  out  4  {funct7[5] (R-type, or I-type funct3=101), funct3}
- out_class  out  3  0 OP, 1 OP-IMM, 2 LUI, 3 AUIPC, 4 LOAD, 5 STORE, 7 illegal
- out_op1, out_op2  out  XLEN  operands
- out_store_data  out  XLEN  rs2 value for STORE
- out_rd  out  5  destination register
- out_wr_en  out  1  writes rd (0 if rd==0)
- out_mem_valid, out_mem_rw  out  1/1  memory access; rw=1 means write
- out_pc  out  XLEN  PC of the instruction
- out_illegal  out  1  unsupported opcode
- bubble_cnt  out  CNT_W  count of load-use bubbles, saturating

## Operation
- **Operand sources.** rs value resolves with priority: x0 → 0; ex match (ex_wr_en, addr≠0) → ex_wr_data; mem match → mem_wr_data; otherwise rf data.
- **Immediates.** All are sign-extended to XLEN.
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - U: {inst[31:12], 12'b0}; for XLEN=64 this is sign-extended from bit 31.
- **Per-class operands and controls.**
  - OP: op1=rs1, op2=rs2.
  - OP-IMM: op1=rs1, op2=I.
  - LUI: op1=0, op2=U.
  - AUIPC: op1=pc, op2=U.
  - LOAD: op1=rs1, op2=I; mem_valid=1, rw=0.
  - STORE: op1=rs1, op2=S, store_data=rs2; mem_valid=1, rw=1, wr_en=0.
  - Illegal: illegal=1, wr_en=0, mem_valid=0; the instruction still flows with out_valid=1.
- **Load-use hazard.** Raised when out_valid, out_class==LOAD, out_rd≠0, and out_rd equals a source actually used by the input instruction (rs1 for OP/OP-IMM/LOAD/STORE; rs2 for OP/STORE) while in_valid.
- **Advance.** The output register advances when adv = !out_valid | out_ready.
- **Handshake.** in_ready = adv & !hazard, or 1 when flush is high.
- **On adv:**
  - If in_valid & !hazard, load the decoded input with out_valid=1.
  - If hazard, load a bubble (out_valid=0) and increment bubble_cnt, saturating at all-ones.
  - Otherwise, out_valid=0.
- **Flush.** Dominates: out_valid←0 next cycle, the input is consumed and dropped, and bubble_cnt is not incremented.

## Timing
- Latency is 1 cycle from input acceptance to out_valid.
- Throughput is 1 instruction per cycle without hazards.
- Each load-use hazard costs exactly 1 bubble cycle. The next cycle, the load has moved to MEM and its data is forwarded from mem_wr_data.
- Outputs are registered. in_ready and rf_rs*_addr are combinational.
- While out_valid & !out_ready, all out_* are held stable and in_ready=0.
- Reset values: out_valid=0, every out_* data/control field=0, bubble_cnt=0. Reset dominates flush.
- Reset mid-stream discards the held instruction and clears the counter.
- When EX and MEM match the same register, EX wins.

## Test plan
- OP-IMM `addi x1,x0,5` → out_class=1, op1=0, op2=5, rd=1, wr_en=1, out_valid one cycle after acceptance.
- `add x3,x1,x2`, ex_wr addr=1 data=7, mem_wr addr=1 data=9, rf rs2=4 → op1=7, op2=4; with ex_wr_addr=0 and mem_wr_addr=0 (x0), op1=0.
- `lw x5,8(x2)` followed by `add x6,x5,x1`:
  - → in_ready=0 for one cycle, a bubble is emitted, and bubble_cnt becomes 1.
  - The add then issues with op1=mem_wr_data.
- Back-pressure: out_ready=0 for 3 cycles → outputs held and in_ready=0; out_ready=1 → the next instruction accepted the same cycle.
- Flush during a hazard and a held output → out_valid=0 next cycle, in_ready=1, bubble_cnt unchanged.
- Corner encodings:
  - `lui x4,0x80000` with XLEN=64 → op2=0xFFFFFFFF80000000.
  - `sw` → wr_en=0, rw=1.
  - Opcode 0x7F → out_illegal=1.
